operand_regfile: RTL and testbench
==================================

Name: operand_regfile

Overview:
Parametrised integer register file with operand capture for the decode/issue stage. It generalises the single rs1 operand register to two registered read ports (rs1, rs2) and one writeback port. It adds hardwired x0, writeback-to-read bypass, and a per-register busy scoreboard that reports RAW hazards to issue control. It sits between the decoder and the execute stage; writeback comes from the retire stage.

Parameters:
XLEN, 32, data width of each register and of every data port
NREG, 32, number of architectural registers (power of two, >= 2)
AW, 5, register address width; must equal log2(NREG)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-low (0 = reset)
rd_en  input  1  capture operands at this edge
rs1_addr  input  AW  source register 1 index
rs2_addr  input  AW  source register 2 index
rs1_data  output  XLEN  registered operand 1
rs2_data  output  XLEN  registered operand 2
rd_valid  output  1  operands captured by previous edge are valid (1-cycle pulse)
rs1_busy  output  1  combinational: rs1 has an outstanding producer
rs2_busy  output  1  combinational: rs2 has an outstanding producer
issue_en  input  1  instruction issued that will write issue_rd
issue_rd  input  AW  destination of issued instruction
wb_en  input  1  writeback strobe
wb_addr  input  AW  writeback destination
wb_data  input  XLEN  writeback value

Behaviour:
- Reset (rst=0, asynchronous): all NREG registers = 0, all busy bits = 0, rs1_data = rs2_data = 0, rd_valid = 0. Reset mid-operation discards pending reads, writes and scoreboard state immediately. Release is synchronous to the next clk edge.
- Write: at posedge, if wb_en and wb_addr != 0, then mem[wb_addr] <= wb_data. Writes to x0 are ignored. mem[0] always reads 0.
- Read, latency 1: at posedge with rd_en=1:
  - rsN_data <= 0 if rsN_addr == 0.
  - Else rsN_data <= wb_data if wb_en and wb_addr == rsN_addr (same-edge bypass).
  - Else rsN_data <= mem[rsN_addr].
  - rd_valid <= 1.
- With rd_en=0: rsN_data hold their value and rd_valid <= 0. rd_valid is a 1-cycle pulse per rd_en cycle. Back-to-back rd_en yields continuous rd_valid.
- Both ports read independently. rs1_addr == rs2_addr is legal and both get identical data.
- Scoreboard, per register i != 0, evaluated each posedge:
  - busy[i] <= 1 if issue_en and issue_rd == i.
  - Else busy[i] <= 0 if wb_en and wb_addr == i.
  - Else busy[i] holds.
  - Simultaneous issue and writeback to the same i: issue wins and busy stays 1, because a new producer supersedes the old one. The data write still occurs.
  - busy[0] is constant 0. issue_en with issue_rd == 0 has no effect.
- Hazard outputs, combinational: rsN_busy = busy[rsN_addr] AND NOT (wb_en AND wb_addr == rsN_addr). A same-cycle writeback clears the hazard because the bypass supplies the data. Issue control must not assert rd_en for an instruction whose rsN_busy = 1.
- No multiple-writeback ordering is enforced; the retire stage guarantees in-order writeback per register.

Test Plan:
- Reset: drive rst=0 mid-stream with busy bits set and data nonzero -> all outputs 0 immediately. After release, reading x5 and x7 returns 0/0 with rd_valid=1 one cycle after rd_en.
- Write then read: wb x3=0xDEADBEEF, next cycle rd_en with rs1=3, rs2=0 -> rs1_data=0xDEADBEEF, rs2_data=0, rd_valid pulses once.
- x0 protection: wb x0=0xFFFFFFFF, then read rs1=0 -> 0. Issue to rd=0 -> rs1_busy stays 0.
- Bypass: same edge wb x9=0x12345678 and rd_en rs1=9, rs2=9 (mem[9]=0x1) -> both outputs 0x12345678. rs1_busy=0 during that cycle even though busy[9] was 1.
- Scoreboard: issue rd=4 -> rs1_busy=1 for rs1=4 next cycle. wb x4 -> busy clears after the edge. Simultaneous issue rd=4 and wb x4 -> busy[4] remains 1 and mem[4] is updated.
- Hold: rd_en=0 for 3 cycles after a read of 0xA5A5A5A5 -> rs1_data holds 0xA5A5A5A5 and rd_valid=0 throughout.

Source files
------------

// File: rtl/operand_regfile.sv
// Integer register file for decode/issue: two registered read ports with
// writeback bypass, hardwired x0, and a per-register busy scoreboard.
module operand_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rd_valid,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] rs1_next;
  logic [XLEN-1:0] rs2_next;
  logic            wb_hit1;
  logic            wb_hit2;

  assign wb_hit1 = wb_en && (wb_addr == rs1_addr);
  assign wb_hit2 = wb_en && (wb_addr == rs2_addr);

  // NOTE: every architectural register must clear on reset, so the array is
  // built from resettable flops rather than an SRAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    rs1_next = mem[rs1_addr];
    if (wb_hit1)          rs1_next = wb_data;
    if (rs1_addr == '0)   rs1_next = '0;
  end

  always_comb begin
    rs2_next = mem[rs2_addr];
    if (wb_hit2)          rs2_next = wb_data;
    if (rs2_addr == '0)   rs2_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rs1_data <= rs1_next;
        rs2_data <= rs2_next;
      end
    end
  end

  // A new producer supersedes an in-flight one, so issue beats writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < NREG; i++) begin
        if (issue_en && (issue_rd == AW'(i)))    busy[i] <= 1'b1;
        else if (wb_en && (wb_addr == AW'(i)))   busy[i] <= 1'b0;
      end
    end
  end

  // A same-cycle writeback clears the hazard since the bypass supplies data.
  assign rs1_busy = busy[rs1_addr] && !wb_hit1;
  assign rs2_busy = busy[rs2_addr] && !wb_hit2;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed and randomized bench for operand_regfile against an
// architectural-level model (register array + pending-producer set).
module tb_operand_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            rd_en;
  logic [AW-1:0]   rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rd_valid, rs1_busy, rs2_busy;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  int checks   = 0;
  int failures = 0;

  // Architectural model state.
  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_pend [NREG];
  logic [XLEN-1:0] e_rs1, e_rs2;
  logic            e_valid;

  operand_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_valid(rd_valid), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] observed,
                       input logic [XLEN-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    e_rs1 = '0; e_rs2 = '0; e_valid = 1'b0;
  endtask

  // Hazard if a producer is pending and no writeback for it arrives now.
  function automatic logic exp_hazard(input logic [AW-1:0] a);
    return m_pend[a] && !(wb_en && wb_addr == a);
  endfunction

  // One clock: drive on the falling edge, check hazards before the rising
  // edge, advance the model, check registered outputs just after the edge.
  task automatic cycle(input logic rd, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic iss, input logic [AW-1:0] ird,
                       input logic wb, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input string tag);
    rd_en = rd; rs1_addr = a1; rs2_addr = a2;
    issue_en = iss; issue_rd = ird;
    wb_en = wb; wb_addr = wa; wb_data = wd;
    #1;
    check({tag, ".rs1_busy"}, XLEN'(rs1_busy), XLEN'(exp_hazard(a1)));
    check({tag, ".rs2_busy"}, XLEN'(rs2_busy), XLEN'(exp_hazard(a2)));
    @(posedge clk);
    // Architecturally a read observes the register after this edge's write.
    if (wb && wa != 0) m_reg[wa] = wd;
    if (rd) begin
      e_rs1 = m_reg[a1];
      e_rs2 = m_reg[a2];
    end
    e_valid = rd;
    if (wb) m_pend[wa] = 1'b0;
    if (iss && ird != 0) m_pend[ird] = 1'b1;
    #1;
    check({tag, ".rs1_data"}, rs1_data, e_rs1);
    check({tag, ".rs2_data"}, rs2_data, e_rs2);
    check({tag, ".rd_valid"}, XLEN'(rd_valid), XLEN'(e_valid));
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] a1, input string tag);
    cycle(1'b0, a1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, '0, tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rs1_data"}, rs1_data, '0);
    check({tag, ".rs2_data"}, rs2_data, '0);
    check({tag, ".rd_valid"}, XLEN'(rd_valid), '0);
    check({tag, ".rs1_busy"}, XLEN'(rs1_busy), '0);
    check({tag, ".rs2_busy"}, XLEN'(rs2_busy), '0);
  endtask

  initial begin
    rst = 1'b0; rd_en = 1'b0; rs1_addr = '0; rs2_addr = '0;
    issue_en = 1'b0; issue_rd = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    rst = 1'b1;

    cycle(1, 5, 7, 0, 0, 0, 0, '0, "rd_after_reset");

    // Write then read, rd_valid pulses once.
    cycle(0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, "wb_x3");
    cycle(1, 3, 0, 0, 0, 0, 0, '0, "rd_x3");
    idle(3, "rd_x3_pulse_end");

    // x0 protection.
    cycle(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, "wb_x0");
    cycle(1, 0, 0, 1, 0, 0, 0, '0, "rd_x0_issue_x0");
    idle(0, "x0_not_busy");

    // Bypass with a pending producer on x9.
    cycle(0, 0, 0, 1, 9, 1, 9, 32'h1, "wb_x9_init");
    idle(9, "x9_busy");
    cycle(1, 9, 9, 0, 0, 1, 9, 32'h12345678, "bypass_x9");

    // Scoreboard set, clear, and issue-beats-writeback.
    cycle(0, 0, 0, 1, 4, 0, 0, '0, "issue_x4");
    idle(4, "x4_busy");
    cycle(0, 4, 4, 0, 0, 1, 4, 32'h44, "wb_x4");
    idle(4, "x4_clear");
    cycle(0, 4, 0, 1, 4, 1, 4, 32'h4444, "issue_wb_x4");
    cycle(1, 4, 0, 0, 0, 0, 0, '0, "x4_still_busy");

    // Hold for three idle cycles.
    cycle(0, 0, 0, 0, 0, 1, 6, 32'hA5A5A5A5, "wb_x6");
    cycle(1, 6, 6, 0, 0, 0, 0, '0, "rd_x6");
    for (int i = 0; i < 3; i++) idle(6, "hold_x6");

    // Mid-stream asynchronous reset with busy bits set and data nonzero.
    cycle(1, 3, 4, 1, 7, 0, 0, '0, "pre_reset");
    rs1_addr = 7; rs2_addr = 4;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_mid");
    @(negedge clk);
    rst = 1'b1;
    cycle(1, 3, 7, 0, 0, 0, 0, '0, "rd_after_mid_reset");

    // Randomized traffic over a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), XLEN'($urandom),
            "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
